// File: rtl/mul4_seq_if.sv
// Start/busy/done handshake bundle between a requester and the mul4_seq multiplier.
interface mul4_seq_if #(
    parameter int N = 4
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul4_seq.sv
// Sequential shift-and-add unsigned multiplier; borrows an external combinational
// ALU for the add step and returns a 2N-bit product after 2N+1 cycles.
module mul4_seq #(
    parameter int         N      = 4,
    parameter logic [2:0] OP_ADD = 3'b100
) (
    input  logic         clk,
    input  logic         reset,
    mul4_seq_if.slave    bus,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_co
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t         state;
    logic [N-1:0]   acc;
    logic [N-1:0]   mq;
    logic [N-1:0]   mcand;
    logic           carry;
    logic [CW-1:0]  count;

    assign alu_a  = acc;
    assign alu_b  = mcand;
    assign alu_op = OP_ADD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            mq          <= '0;
            mcand       <= '0;
            carry       <= 1'b0;
            count       <= '0;
            bus.product <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        mcand    <= bus.a;
                        mq       <= bus.b;
                        acc      <= '0;
                        carry    <= 1'b0;
                        count    <= '0;
                        state    <= ADD;
                        bus.busy <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ADD: begin
                    if (mq[0]) begin
                        acc   <= alu_result;
                        carry <= alu_co;
                    end else begin
                        carry <= 1'b0;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    // {carry,acc,mq} shifted right by one as a single 2N+1-bit word
                    carry <= 1'b0;
                    acc   <= {carry, acc[N-1:1]};
                    mq    <= {acc[0], mq[N-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        bus.product <= {carry, acc, mq[N-1:1]};
                        state       <= DONE;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                    end else begin
                        state <= ADD;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul4_seq.sv
// Randomized self-checking bench for mul4_seq with a behavioural ALU and product model.
module tb_mul4_seq;
    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_op;
    logic         alu_co;
    int           total = 0;
    int           bad   = 0;

    mul4_seq_if #(.N(N)) bus ();

    mul4_seq #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_co     (alu_co)
    );

    // ALU: plain addition when asked for OP_ADD
    assign {alu_co, alu_result} = (alu_op == 3'b100) ? ({1'b0, alu_a} + {1'b0, alu_b}) : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start; leaves the bench at the first cycle the op is in flight.
    task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb, input bit hold);
        bus.a     = ta;
        bus.b     = tb;
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    // Follow an op to completion; glitch_at>0 pulses a stray start at that in-flight cycle.
    task automatic finish_op(input string tag, input logic [2*N-1:0] exp_prod,
                             input logic [N-1:0] exp_mcand, input int glitch_at);
        int lat;
        logic [2*N-1:0] old_prod;
        lat = 1;
        old_prod = bus.product;
        chk({tag, ".mcand"}, 32'(alu_b), 32'(exp_mcand));
        while (!bus.done && lat < 20) begin
            chk({tag, ".busy"}, 32'(bus.busy), 1);
            if (lat == 2) chk({tag, ".hold"}, 32'(bus.product), 32'(old_prod));
            if (glitch_at > 0 && lat == glitch_at) begin
                bus.a     = 4'(($urandom));
                bus.b     = 4'(($urandom));
                bus.start = 1'b1;
            end else if (glitch_at > 0 && lat == glitch_at + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 9);
        chk({tag, ".prod"}, 32'(bus.product), 32'(exp_prod));
        chk({tag, ".busy_done"}, 32'(bus.busy), 0);
    endtask

    task automatic idle_check(input string tag, input logic [2*N-1:0] exp_prod);
        bus.a = 4'(($urandom));
        bus.b = 4'(($urandom));
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.done), 0);
        chk({tag, ".idle_prod"}, 32'(bus.product), 32'(exp_prod));
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        int           g;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.prod", 32'(bus.product), 0);
        chk("rst.op", 32'(alu_op), 32'h4);
        chk("rst.alu_a", 32'(alu_a), 0);
        reset = 1'b0;
        @(negedge clk);

        launch(4'hF, 4'hF, 1'b0); finish_op("ff", 8'hE1, 4'hF, 0); idle_check("ff", 8'hE1);
        launch(4'h9, 4'h5, 1'b0); finish_op("95", 8'h2D, 4'h9, 0); idle_check("95", 8'h2D);
        launch(4'h0, 4'hB, 1'b0); finish_op("0b", 8'h00, 4'h0, 0); idle_check("0b", 8'h00);
        launch(4'hA, 4'h0, 1'b0); finish_op("a0", 8'h00, 4'hA, 0); idle_check("a0", 8'h00);
        launch(4'h3, 4'h7, 1'b0); finish_op("ign", 8'h15, 4'h3, 3); idle_check("ign", 8'h15);

        // start held across done: DONE restarts straight into a new op
        launch(4'h2, 4'h6, 1'b1);
        finish_op("b2b1", 8'h0C, 4'h2, 0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b.restart_busy", 32'(bus.busy), 1);
        finish_op("b2b2", 8'h0C, 4'h2, 0);
        idle_check("b2b", 8'h0C);

        // reset during a SHIFT state discards the op and clears product
        launch(4'h7, 4'h7, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst.busy", 32'(bus.busy), 0);
        chk("mid_rst.prod", 32'(bus.product), 0);
        for (int i = 0; i < 10; i++) begin
            chk("mid_rst.no_done", 32'(bus.done), 0);
            @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            g  = int'($urandom_range(0, 7));
            launch(ra, rb, 1'b0);
            finish_op($sformatf("rnd%0d", i), 8'(ra * rb), ra, g);
            if ($urandom_range(0, 1) == 1) idle_check("rnd", 8'(ra * rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
